// File: rtl/lc_ctrl_pkg.sv
// rtl/lc_ctrl_pkg.sv - lifecycle multi-bit signal types shared with lc_ctrl
// Purpose: lc_tx_t encoding used on the clock-bypass handshake.
//   On/Off are the only valid values; every other 4-bit pattern is invalid.
package lc_ctrl_pkg;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

endpackage

// File: rtl/lc_pwr_init_seq_pkg.sv
// rtl/lc_pwr_init_seq_pkg.sv - state encoding and helpers for lc_pwr_init_seq
// Purpose: init sequencer state enum (also the debug encoding on seq_state_o)
//   and a small max helper used for counter sizing.
package lc_pwr_init_seq_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDelay = 3'd1,
    StInit  = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwrmgr_pkg.sv
// rtl/pwrmgr_pkg.sv - power manager <-> lc_ctrl handshake structures
// Purpose: request/response structs exchanged between the power-side
//   sequencer and lc_ctrl.
package pwrmgr_pkg;

  typedef struct packed {
    logic lc_init;
  } pwr_lc_req_t;

  typedef struct packed {
    logic lc_done;
    logic lc_idle;
  } pwr_lc_rsp_t;

endpackage

// File: rtl/lc_byp_ack_gen.sv
// rtl/lc_byp_ack_gen.sv - fixed-latency clock-bypass acknowledge generator
// Purpose: acknowledges a stable On request BypAckDelay edges after it is
//   first sampled; any non-On request (including invalid encodings) drops the
//   ack to Off on the next edge.
// Ports:
//   clk     in  : clock
//   reset_n in  : synchronous active-low reset
//   enable  in  : path runs only while high; low forces ack Off
//   req     in  : bypass request (lc_tx_t)
//   ack     out : registered bypass acknowledge, only ever On or Off
module lc_byp_ack_gen
  import lc_ctrl_pkg::*;
#(
  parameter int unsigned BypAckDelay = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   enable,
  input  lc_tx_t req,
  output lc_tx_t ack
);

  localparam int unsigned AW = $clog2(BypAckDelay + 1);
  localparam logic [AW-1:0] CntSat  = AW'(BypAckDelay);
  // Count value seen on the edge that completes BypAckDelay consecutive On samples.
  localparam logic [AW-1:0] ArmLast = AW'(BypAckDelay - 1);

  logic [AW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      cnt_q <= '0;
      ack   <= Off;
    end else if (req == On) begin
      if (cnt_q != CntSat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      ack <= (cnt_q >= ArmLast) ? On : Off;
    end else begin
      cnt_q <= '0;
      ack   <= Off;
    end
  end

endmodule

// File: rtl/lc_pwr_init_seq.sv
// rtl/lc_pwr_init_seq.sv - power-side lc_ctrl init and clock-bypass sequencer
// Purpose: after power-good, waits InitDelay cycles, raises lc_init and waits
//   for lc_done under a DoneTimeout watchdog; answers clock-bypass requests.
// Ports:
//   clk               in  : clock
//   reset_n           in  : synchronous active-low reset
//   cptra_pwrgood     in  : power-good level; low aborts everything
//   pwr_lc_o          in  : lc_ctrl response (lc_done, lc_idle)
//   pwr_lc_i          out : lc_ctrl request (only lc_init driven)
//   lc_clk_byp_req_o  in  : clock-bypass request from lc_ctrl
//   lc_clk_byp_ack_i  out : clock-bypass acknowledge to lc_ctrl
//   init_done_o       out : sticky, lc_done seen in INIT
//   init_err_o        out : sticky, timeout or lc_done seen in DELAY
//   seq_state_o       out : current state encoding for debug
module lc_pwr_init_seq
  import lc_ctrl_pkg::*;
  import pwrmgr_pkg::*;
  import lc_pwr_init_seq_pkg::*;
#(
  parameter int unsigned InitDelay   = 500,
  parameter int unsigned DoneTimeout = 10000,
  parameter int unsigned BypAckDelay = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cptra_pwrgood,
  input  pwr_lc_rsp_t pwr_lc_o,
  output pwr_lc_req_t pwr_lc_i,
  input  lc_tx_t      lc_clk_byp_req_o,
  output lc_tx_t      lc_clk_byp_ack_i,
  output logic        init_done_o,
  output logic        init_err_o,
  output logic [2:0]  seq_state_o
);

  localparam int unsigned CntMax = max_u(InitDelay, DoneTimeout);
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam logic [CW-1:0] CntSat   = CW'(CntMax);
  localparam logic [CW-1:0] InitLast = CW'(InitDelay - 1);
  localparam logic [CW-1:0] DoneLast = CW'(DoneTimeout - 1);

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          lc_init_q;

  // lc_idle is observed for debug visibility only and never steers the FSM.
  logic unused_lc_idle;
  assign unused_lc_idle = pwr_lc_o.lc_idle;

  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n || !cptra_pwrgood) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lc_init_q   <= 1'b0;
      init_done_o <= 1'b0;
      init_err_o  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StDelay;
          cnt_q   <= '0;
        end
        StDelay: begin
          // An lc_done before we ever asked for init is a protocol error.
          if (pwr_lc_o.lc_done) begin
            state_q    <= StError;
            init_err_o <= 1'b1;
          end else if (cnt_q == InitLast) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            lc_init_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StInit: begin
          // lc_done takes precedence over a coincident timeout.
          if (pwr_lc_o.lc_done) begin
            state_q     <= StDone;
            lc_init_q   <= 1'b0;
            init_done_o <= 1'b1;
          end else if (cnt_q == DoneLast) begin
            state_q    <= StError;
            lc_init_q  <= 1'b0;
            init_err_o <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDone, StError: begin
          state_q <= state_q;
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          lc_init_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pwr_lc_i         = '0;
    pwr_lc_i.lc_init = lc_init_q;
  end

  assign seq_state_o = state_q;

  lc_byp_ack_gen #(
    .BypAckDelay(BypAckDelay)
  ) u_byp_ack_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (cptra_pwrgood),
    .req    (lc_clk_byp_req_o),
    .ack    (lc_clk_byp_ack_i)
  );

endmodule

// File: tb/tb_lc_pwr_init_seq.sv
// tb/tb_lc_pwr_init_seq.sv - self-checking bench for lc_pwr_init_seq
module tb_lc_pwr_init_seq;
  import lc_ctrl_pkg::*;
  import pwrmgr_pkg::*;

  localparam int unsigned INIT_DLY = 500;
  localparam int unsigned DONE_TO  = 100;
  localparam int unsigned BYP_DLY  = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DELAY = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cptra_pwrgood;
  pwr_lc_rsp_t rsp;
  pwr_lc_req_t req;
  lc_tx_t      byp_req;
  lc_tx_t      byp_ack;
  logic        init_done;
  logic        init_err;
  logic [2:0]  seq_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lc_pwr_init_seq #(
    .InitDelay  (INIT_DLY),
    .DoneTimeout(DONE_TO),
    .BypAckDelay(BYP_DLY)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cptra_pwrgood   (cptra_pwrgood),
    .pwr_lc_o        (rsp),
    .pwr_lc_i        (req),
    .lc_clk_byp_req_o(byp_req),
    .lc_clk_byp_ack_i(byp_ack),
    .init_done_o     (init_done),
    .init_err_o      (init_err),
    .seq_state_o     (seq_state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [2:0] st, input logic init,
                            input logic done, input logic err);
    chk({tag, "_state"}, 32'(seq_state), 32'(st));
    chk({tag, "_lc_init"}, 32'(req.lc_init), 32'(init));
    chk({tag, "_done"}, 32'(init_done), 32'(done));
    chk({tag, "_err"}, 32'(init_err), 32'(err));
  endtask

  // Raise power-good from IDLE; lc_init must rise exactly at edge INIT_DLY+1.
  task automatic raise_to_init(input string tag);
    cptra_pwrgood = 1'b1;
    tick(INIT_DLY);
    chk_status({tag, "_pre_init"}, S_DELAY, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_status({tag, "_init"}, S_INIT, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic lc_tx_t rand_invalid();
    logic [3:0] v;
    do v = 4'($urandom); while (v == 4'b0101 || v == 4'b1010);
    return lc_tx_t'(v);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int seen;
    int run;
    int len;
    int kind;
    lc_tx_t v;
    logic pg;

    reset_n       = 1'b0;
    cptra_pwrgood = 1'b0;
    rsp           = '0;
    byp_req       = Off;
    tick(3);
    chk_status("reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    chk("reset_ack", 32'(byp_ack), 32'(Off));
    reset_n = 1'b1;
    tick(2);
    chk_status("no_pwrgood", S_IDLE, 1'b0, 1'b0, 1'b0);

    // Normal completion with a random lc_done latency.
    raise_to_init("a");
    w = $urandom_range(1, DONE_TO - 10);
    rsp.lc_idle = 1'($urandom);
    tick(w);
    chk_status("a_wait", S_INIT, 1'b1, 1'b0, 1'b0);
    rsp.lc_done = 1'b1;
    tick(1);
    chk_status("a_done", S_DONE, 1'b0, 1'b1, 1'b0);
    rsp.lc_done = 1'($urandom);
    rsp.lc_idle = 1'($urandom);
    tick(7);
    chk_status("a_terminal", S_DONE, 1'b0, 1'b1, 1'b0);
    rsp = '0;

    // Power-good drop from DONE, then mid-INIT, then full-delay repeat into timeout.
    cptra_pwrgood = 1'b0;
    tick(1);
    chk_status("b_drop_done", S_IDLE, 1'b0, 1'b0, 1'b0);
    raise_to_init("b");
    tick($urandom_range(1, DONE_TO - 2));
    cptra_pwrgood = 1'b0;
    tick(1);
    chk_status("b_drop_init", S_IDLE, 1'b0, 1'b0, 1'b0);
    raise_to_init("c");
    tick(DONE_TO - 1);
    chk_status("c_pre_to", S_INIT, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_status("c_timeout", S_ERROR, 1'b0, 1'b0, 1'b1);
    tick(3);
    chk_status("c_terminal", S_ERROR, 1'b0, 1'b0, 1'b1);

    // Reset asserted mid-DELAY restarts the full sequence.
    cptra_pwrgood = 1'b0;
    tick(1);
    cptra_pwrgood = 1'b1;
    tick($urandom_range(2, 100));
    chk_status("r_delay", S_DELAY, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick(1);
    chk_status("r_reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(1);
    chk_status("r_restart", S_DELAY, 1'b0, 1'b0, 1'b0);
    tick(INIT_DLY - 1);
    chk_status("r_pre_init", S_DELAY, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_status("r_init", S_INIT, 1'b1, 1'b0, 1'b0);

    // lc_done during DELAY is an error and lc_init never rises.
    cptra_pwrgood = 1'b0;
    tick(1);
    cptra_pwrgood = 1'b1;
    w = $urandom_range(2, INIT_DLY);
    tick(w - 1);
    rsp.lc_done = 1'b1;
    tick(1);
    chk_status("d_early_done", S_ERROR, 1'b0, 1'b0, 1'b1);
    rsp.lc_done = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(INIT_DLY) + 10; i++) begin
      tick(1);
      if (req.lc_init) seen++;
    end
    chk("d_never_init", 32'(seen), 32'd0);
    chk_status("d_terminal", S_ERROR, 1'b0, 1'b0, 1'b1);

    // lc_done coincident with the timeout edge: done wins.
    cptra_pwrgood = 1'b0;
    tick(1);
    raise_to_init("e");
    tick(DONE_TO - 1);
    rsp.lc_done = 1'b1;
    tick(1);
    chk_status("e_tie", S_DONE, 1'b0, 1'b1, 1'b0);
    rsp.lc_done = 1'b0;

    // Clock bypass: directed latency, invalid encoding, short pulse, power drop.
    byp_req = On;
    tick(BYP_DLY - 1);
    chk("byp_early", 32'(byp_ack), 32'(Off));
    tick(1);
    chk("byp_rise", 32'(byp_ack), 32'(On));
    tick(5);
    chk("byp_hold", 32'(byp_ack), 32'(On));
    byp_req = rand_invalid();
    tick(1);
    chk("byp_invalid", 32'(byp_ack), 32'(Off));
    byp_req = On;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("byp_pulse", 32'(byp_ack), 32'(Off));
    end
    byp_req = Off;
    tick(1);
    chk("byp_pulse_end", 32'(byp_ack), 32'(Off));
    byp_req = On;
    tick(BYP_DLY + 1);
    chk("byp_pg_pre", 32'(byp_ack), 32'(On));
    cptra_pwrgood = 1'b0;
    tick(1);
    chk("byp_pg_drop", 32'(byp_ack), 32'(Off));
    tick(2);
    chk("byp_pg_low", 32'(byp_ack), 32'(Off));

    // Randomized segments against a run-length reference: ack is On exactly
    // when the last BYP_DLY samples were all On with power good.
    cptra_pwrgood = 1'b1;
    byp_req = Off;
    tick(1);
    run = 0;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 8);
      v    = (kind == 0) ? On : (kind == 1) ? Off : rand_invalid();
      pg   = ($urandom_range(0, 9) != 0);
      byp_req       = v;
      cptra_pwrgood = pg;
      for (int k = 0; k < len; k++) begin
        tick(1);
        run = (pg && v == On) ? run + 1 : 0;
        chk("byp_rand", 32'(byp_ack), (run >= int'(BYP_DLY)) ? 32'(On) : 32'(Off));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
